// File: rtl/char_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : char_position_ctrl
// Description : Position controller for a magnifiable glyph window. Turns
//               held direction requests into clamped or wrapped steps with
//               hold-to-repeat, applies magnification and recentre, and
//               publishes window bounds only on frame_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module char_position_ctrl #(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 400,
    parameter int GLYPH_W       = 8,
    parameter int GLYPH_H       = 16,
    parameter int MAG_W         = 2,
    parameter int COORD_W       = 10,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 6,
    parameter int WRAP          = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [3:0]         move_req,
    input  logic [MAG_W-1:0]   mag_sel,
    input  logic               recenter,
    output logic [COORD_W-1:0] hor_start,
    output logic [COORD_W-1:0] hor_end,
    output logic [COORD_W-1:0] ver_start,
    output logic [COORD_W-1:0] ver_end,
    output logic [3:0]         at_edge,
    output logic               moved
);

    // One extra bit so every sum and difference stays unsigned without wrap.
    typedef logic [COORD_W:0] coord_t;

    localparam coord_t c_HACT = coord_t'(H_ACTIVE);
    localparam coord_t c_VACT = coord_t'(V_ACTIVE);
    localparam coord_t c_GW   = coord_t'(GLYPH_W);
    localparam coord_t c_GH   = coord_t'(GLYPH_H);
    localparam coord_t c_ONE  = coord_t'(1);

    localparam logic [COORD_W-1:0] c_HX0    = COORD_W'((H_ACTIVE - GLYPH_W) / 2);
    localparam logic [COORD_W-1:0] c_VY0    = COORD_W'((V_ACTIVE - GLYPH_H) / 2);
    localparam logic [COORD_W-1:0] c_HEND0  = COORD_W'((H_ACTIVE - GLYPH_W) / 2 + GLYPH_W);
    localparam logic [COORD_W-1:0] c_VEND0  = COORD_W'((V_ACTIVE - GLYPH_H) / 2 + GLYPH_H);
    localparam logic [COORD_W-1:0] c_HACT_O = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] c_VACT_O = COORD_W'(V_ACTIVE);

    localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    typedef logic [c_CNT_W-1:0] cnt_t;
    localparam cnt_t c_DELAY   = cnt_t'(REPEAT_DELAY);
    localparam cnt_t c_PERIOD  = cnt_t'(REPEAT_PERIOD);
    localparam cnt_t c_CNT_ONE = cnt_t'(1);

    // Working state
    logic [COORD_W-1:0] r_hx;
    logic [COORD_W-1:0] r_vy;
    logic [MAG_W-1:0]   r_mAct;
    logic [MAG_W-1:0]   r_magPend;
    logic               r_magPendValid;
    logic [3:0]         r_prevReq;
    logic [3:0]         r_rep;
    cnt_t               r_cnt [4];

    // Combinational helpers
    logic [MAG_W-1:0] w_mEff;
    coord_t           w_sx, w_sy, w_hmax, w_vmax;
    coord_t           w_hBase, w_vBase, w_hEnd, w_vEnd, w_hNext, w_vNext;
    logic [3:0]       w_edge, w_block, w_fire, w_step;
    cnt_t             w_cntInc [4];
    logic             w_changed;
    logic             w_unused;

    // Effective magnification for this cycle (a pending change lands on frame_tick),
    // derived step sizes, limits and the position clamped to those limits.
    always_comb begin
        w_mEff  = (frame_tick && r_magPendValid) ? r_magPend : r_mAct;
        w_sx    = c_GW * (coord_t'(w_mEff) + c_ONE);
        w_sy    = c_GH * (coord_t'(w_mEff) + c_ONE);
        w_hmax  = c_HACT - w_sx;
        w_vmax  = c_VACT - w_sy;
        w_hBase = ({1'b0, r_hx} > w_hmax) ? w_hmax : {1'b0, r_hx};
        w_vBase = ({1'b0, r_vy} > w_vmax) ? w_vmax : {1'b0, r_vy};
        w_hEnd  = w_hBase + w_sx;
        w_vEnd  = w_vBase + w_sy;
    end

    // Decode requests: press edges, opposing-pair cancellation and repeat firing.
    always_comb begin
        w_edge  = move_req & ~r_prevReq;
        w_block = {{2{move_req[2] & move_req[3]}}, {2{move_req[0] & move_req[1]}}};
        for (int i = 0; i < 4; i++) begin
            w_cntInc[i] = r_cnt[i] + c_CNT_ONE;
            w_fire[i]   = frame_tick & move_req[i] & r_prevReq[i] &
                          (r_rep[i] ? (w_cntInc[i] == c_PERIOD) : (w_cntInc[i] == c_DELAY));
        end
        w_step = move_req & ~w_block & (w_edge | w_fire);
    end

    // Next working position: recentre wins over any step on either axis.
    always_comb begin
        w_hNext = w_hBase;
        w_vNext = w_vBase;
        if (recenter) begin
            w_hNext = w_hmax >> 1;
            w_vNext = w_vmax >> 1;
        end else begin
            if (w_step[2]) begin
                w_hNext = (w_hBase >= w_sx) ? (w_hBase - w_sx) : ((WRAP != 0) ? w_hmax : '0);
            end else if (w_step[3]) begin
                w_hNext = (w_hBase + w_sx <= w_hmax) ? (w_hBase + w_sx) : ((WRAP != 0) ? '0 : w_hmax);
            end
            if (w_step[0]) begin
                w_vNext = (w_vBase >= w_sy) ? (w_vBase - w_sy) : ((WRAP != 0) ? w_vmax : '0);
            end else if (w_step[1]) begin
                w_vNext = (w_vBase + w_sy <= w_vmax) ? (w_vBase + w_sy) : ((WRAP != 0) ? '0 : w_vmax);
            end
        end
        w_changed = (w_hBase[COORD_W-1:0] != hor_start) || (w_hEnd[COORD_W-1:0] != hor_end) ||
                    (w_vBase[COORD_W-1:0] != ver_start) || (w_vEnd[COORD_W-1:0] != ver_end);
    end

    // Edge flags follow the published bounds so they never tear mid-frame.
    assign at_edge = {hor_end == c_HACT_O, hor_start == '0, ver_end == c_VACT_O, ver_start == '0};

    // Upper bits of these sums are provably zero after clamping.
    assign w_unused = ^{w_hNext[COORD_W], w_vNext[COORD_W], w_hEnd[COORD_W], w_vEnd[COORD_W]};

    // State update: working position, magnification, repeat counters and the
    // published bounds, which load only on frame_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hx           <= c_HX0;
            r_vy           <= c_VY0;
            r_mAct         <= '0;
            r_magPend      <= '0;
            r_magPendValid <= 1'b0;
            r_prevReq      <= '0;
            r_rep          <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
            hor_start      <= c_HX0;
            hor_end        <= c_HEND0;
            ver_start      <= c_VY0;
            ver_end        <= c_VEND0;
            moved          <= 1'b0;
        end else begin
            r_hx           <= w_hNext[COORD_W-1:0];
            r_vy           <= w_vNext[COORD_W-1:0];
            r_mAct         <= w_mEff;
            r_magPend      <= mag_sel;
            r_magPendValid <= (mag_sel != r_magPend) || (r_magPendValid && !frame_tick);
            r_prevReq      <= move_req;
            for (int i = 0; i < 4; i++) begin
                if (!move_req[i]) begin
                    r_cnt[i] <= '0;
                    r_rep[i] <= 1'b0;
                end else if (!w_block[i]) begin
                    if (w_edge[i]) begin
                        r_cnt[i] <= '0;
                        r_rep[i] <= 1'b0;
                    end else if (frame_tick) begin
                        if (w_fire[i]) begin
                            r_cnt[i] <= '0;
                            r_rep[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= w_cntInc[i];
                        end
                    end
                end
            end
            if (frame_tick) begin
                hor_start <= w_hBase[COORD_W-1:0];
                hor_end   <= w_hEnd[COORD_W-1:0];
                ver_start <= w_vBase[COORD_W-1:0];
                ver_end   <= w_vEnd[COORD_W-1:0];
                moved     <= w_changed;
            end else begin
                moved     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_position_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_position_ctrl
// Description : Bench for char_position_ctrl. Two instances (saturate and
//               wrap) share stimulus; a behavioural model predicts the
//               published bounds every cycle, plus hand-computed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_position_ctrl;

    localparam int HA = 640;
    localparam int VA = 400;
    localparam int GW = 8;
    localparam int GH = 16;
    localparam int RD = 30;
    localparam int RP = 6;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       recenter   = 1'b0;
    logic [3:0] move_req   = '0;
    logic [1:0] mag_sel    = '0;

    logic [9:0] hs0, he0, vs0, ve0, hs1, he1, vs1, ve1;
    logic [3:0] ae0, ae1;
    logic       mv0, mv1;

    int nAsserts = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    char_position_ctrl #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .GLYPH_W(GW), .GLYPH_H(GH), .MAG_W(2), .COORD_W(10),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .WRAP(0)
    ) dut0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_req(move_req),
        .mag_sel(mag_sel), .recenter(recenter), .hor_start(hs0), .hor_end(he0),
        .ver_start(vs0), .ver_end(ve0), .at_edge(ae0), .moved(mv0)
    );

    char_position_ctrl #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .GLYPH_W(GW), .GLYPH_H(GH), .MAG_W(2), .COORD_W(10),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .WRAP(1)
    ) dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_req(move_req),
        .mag_sel(mag_sel), .recenter(recenter), .hor_start(hs1), .hor_end(he1),
        .ver_start(vs1), .ver_end(ve1), .at_edge(ae1), .moved(mv1)
    );

    // ---------------- behavioural model (index 0 = saturate, 1 = wrap) -----
    int   mHx [2];
    int   mVy [2];
    int   pHs [2];
    int   pHe [2];
    int   pVs [2];
    int   pVe [2];
    bit   pMv [2];
    int   mAct;
    int   magLast;
    logic [3:0] prevReq;
    int   held [4];

    task automatic modelInit();
        for (int k = 0; k < 2; k++) begin
            mHx[k] = (HA - GW) / 2;
            mVy[k] = (VA - GH) / 2;
            pHs[k] = mHx[k];
            pHe[k] = mHx[k] + GW;
            pVs[k] = mVy[k];
            pVe[k] = mVy[k] + GH;
            pMv[k] = 1'b0;
        end
        mAct    = 0;
        magLast = 0;
        prevReq = '0;
        for (int i = 0; i < 4; i++) held[i] = 0;
    endtask

    task automatic modelStep();
        int mEff, sx, sy, hmax, vmax, h, v;
        bit opp, stp [4];
        mEff = frame_tick ? magLast : mAct;
        sx   = GW * (mEff + 1);
        sy   = GH * (mEff + 1);
        hmax = HA - sx;
        vmax = VA - sy;
        for (int i = 0; i < 4; i++) begin
            opp    = (i < 2) ? (move_req[0] && move_req[1]) : (move_req[2] && move_req[3]);
            stp[i] = 1'b0;
            if (!move_req[i]) begin
                held[i] = 0;
            end else if (!opp) begin
                if (!prevReq[i]) begin
                    stp[i]  = 1'b1;
                    held[i] = 0;
                end else if (frame_tick) begin
                    held[i]++;
                    if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)) stp[i] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            h = (mHx[k] > hmax) ? hmax : mHx[k];
            v = (mVy[k] > vmax) ? vmax : mVy[k];
            if (frame_tick) begin
                pMv[k] = (h != pHs[k]) || (h + sx != pHe[k]) || (v != pVs[k]) || (v + sy != pVe[k]);
                pHs[k] = h;
                pHe[k] = h + sx;
                pVs[k] = v;
                pVe[k] = v + sy;
            end else begin
                pMv[k] = 1'b0;
            end
            if (recenter) begin
                h = hmax / 2;
                v = vmax / 2;
            end else begin
                if (stp[2])      h = (h >= sx) ? h - sx : ((k == 1) ? hmax : 0);
                else if (stp[3]) h = (h + sx <= hmax) ? h + sx : ((k == 1) ? 0 : hmax);
                if (stp[0])      v = (v >= sy) ? v - sy : ((k == 1) ? vmax : 0);
                else if (stp[1]) v = (v + sy <= vmax) ? v + sy : ((k == 1) ? 0 : vmax);
            end
            mHx[k] = h;
            mVy[k] = v;
        end
        mAct    = mEff;
        magLast = int'(mag_sel);
        prevReq = move_req;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) modelInit();
        else       modelStep();
    end

    // ---------------- per-cycle comparison against the model ---------------
    task automatic checkInst(input int k, input logic [9:0] a, input logic [9:0] b,
                             input logic [9:0] c, input logic [9:0] d,
                             input logic [3:0] e, input logic m);
        logic [3:0] expE;
        expE = {pHe[k] == HA, pHs[k] == 0, pVe[k] == VA, pVs[k] == 0};
        nAsserts++;
        if (a !== 10'(pHs[k]) || b !== 10'(pHe[k]) || c !== 10'(pVs[k]) ||
            d !== 10'(pVe[k]) || e !== expE || m !== pMv[k]) begin
            nFail++;
            $display("FAIL model_inst%0d t=%0t: got hs=%0d he=%0d vs=%0d ve=%0d edge=%b moved=%b, want hs=%0d he=%0d vs=%0d ve=%0d edge=%b moved=%b",
                     k, $time, a, b, c, d, e, m, pHs[k], pHe[k], pVs[k], pVe[k], expE, pMv[k]);
        end
    endtask

    always @(negedge clk) begin
        checkInst(0, hs0, he0, vs0, ve0, ae0, mv0);
        checkInst(1, hs1, he1, vs1, ve1, ae1, mv1);
    end

    // ---------------- directed helpers -------------------------------------
    task automatic lit(input string nm, input int act, input int exp);
        nAsserts++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic press(input logic [3:0] r);
        move_req = r;
        cyc(1);
        move_req = '0;
        cyc(1);
    endtask

    initial begin
        #1 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        lit("reset_hs", int'(hs0), 316);
        lit("reset_he", int'(he0), 324);
        lit("reset_vs", int'(vs0), 192);
        lit("reset_ve", int'(ve0), 208);
        lit("reset_edge", int'(ae0), 0);
        lit("reset_moved", int'(mv0), 0);

        // single step right
        move_req = 4'b1000;
        cyc(3);
        move_req = '0;
        tick();
        lit("step_hs", int'(hs0), 324);
        lit("step_he", int'(he0), 332);
        lit("step_moved", int'(mv0), 1);
        cyc(1);
        lit("step_moved_one_clk", int'(mv0), 0);

        // holding right for fewer than REPEAT_DELAY frames steps once
        move_req = 4'b1000;
        cyc(2);
        repeat (5) begin
            tick();
            cyc(1);
        end
        move_req = '0;
        lit("hold_once_hs", int'(hs0), 332);

        // recentre, then auto-repeat left for 42 frames
        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;
        move_req = 4'b0100;
        cyc(2);
        repeat (42) begin
            tick();
            cyc(1);
        end
        lit("repeat_hs_frame42", int'(hs0), 292);
        move_req = '0;
        tick();
        lit("repeat_last_step", int'(hs0), 284);
        cyc(1);
        tick();
        lit("repeat_released", int'(hs0), 284);
        lit("repeat_released_moved", int'(mv0), 0);

        // saturate vs wrap at the left edge
        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;
        repeat (40) press(4'b0100);
        tick();
        lit("sat_hs", int'(hs0), 0);
        lit("sat_edge_left", int'(ae0[2]), 1);
        lit("wrap_hs", int'(hs1), 632);
        cyc(1);
        press(4'b0100);
        tick();
        lit("sat_again_hs", int'(hs0), 0);
        lit("sat_again_moved", int'(mv0), 0);
        lit("wrap_again_hs", int'(hs1), 624);

        // magnify at the bottom edge
        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;
        repeat (12) press(4'b0010);
        tick();
        lit("bottom_vs", int'(vs0), 384);
        mag_sel = 2'd3;
        cyc(2);
        tick();
        lit("mag_vs", int'(vs0), 336);
        lit("mag_height", int'(ve0) - int'(vs0), 64);
        lit("mag_edge_bottom", int'(ae0[1]), 1);
        lit("mag_wrap_vs", int'(vs1), 336);
        cyc(1);
        press(4'b0010);
        tick();
        lit("mag_sat_down", int'(vs0), 336);
        lit("mag_wrap_down", int'(vs1), 0);

        // conflicts
        mag_sel = 2'd0;
        cyc(2);
        tick();
        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;
        tick();
        lit("centre_vs", int'(vs0), 192);
        move_req = 4'b0011;
        cyc(3);
        tick();
        lit("updown_cancel_vs", int'(vs0), 192);
        move_req = '0;
        cyc(1);
        press(4'b0100);
        press(4'b0100);
        move_req = 4'b1000;
        recenter = 1'b1;
        cyc(1);
        move_req = '0;
        recenter = 1'b0;
        tick();
        lit("recenter_priority_hs", int'(hs0), 316);

        // randomized run against the model, with one asynchronous reset
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2 reset = 1'b1;
                #1;
                lit("async_reset_hs", int'(hs0), 316);
                lit("async_reset_ve", int'(ve0), 208);
                cyc(2);
                reset = 1'b0;
            end
            frame_tick = ($urandom_range(0, 1) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 47) == 0) move_req[b] = ~move_req[b];
            end
            recenter = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 149) == 0) mag_sel = 2'($urandom_range(0, 3));
            cyc(1);
        end
        frame_tick = 1'b0;
        move_req   = '0;
        recenter   = 1'b0;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
`default_nettype wire
